// File: rtl/harv_wb_pkg.sv
// Shared types and lane helpers for the HARV data-memory to Wishbone bridge.
// Pure functions only: no latency, no backpressure of their own.
package harv_wb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // ben encoding from the core: 00 byte, 01 half, 1x word
  function automatic mem_size_t decode_ben(input logic [1:0] ben);
    if (ben[1]) begin
      return SZ_WORD;
    end else if (ben[0]) begin
      return SZ_HALF;
    end else begin
      return SZ_BYTE;
    end
  endfunction

  function automatic logic [3:0] lane_sel(input mem_size_t size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: return 4'b0001 << ofs;
      SZ_HALF: return 4'b0011 << ofs;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_dat(input mem_size_t size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] ofs);
    case (size)
      SZ_HALF: return ofs[0];
      SZ_WORD: return |ofs;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/harv_load_align.sv
// Extracts the addressed byte/half from a bus word and sign/zero extends it.
// Combinational, zero latency; no backpressure.
module harv_load_align
  import harv_wb_pkg::*;
(
  input  logic [31:0] dat_i,
  input  mem_size_t   size_i,
  input  logic [1:0]  ofs_i,
  input  logic        usgn_i,
  output logic [31:0] dat_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dat_i[7:0];
    case (ofs_i)
      2'd0: byte_sel = dat_i[7:0];
      2'd1: byte_sel = dat_i[15:8];
      2'd2: byte_sel = dat_i[23:16];
      default: byte_sel = dat_i[31:24];
    endcase
    half_sel = ofs_i[1] ? dat_i[31:16] : dat_i[15:0];

    dat_o = dat_i;
    case (size_i)
      SZ_BYTE: dat_o = {{24{~usgn_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: dat_o = {{16{~usgn_i & half_sel[15]}}, half_sel};
      default: dat_o = dat_i;
    endcase
  end

endmodule

// File: rtl/harv_dmem_wb_bridge.sv
// HARV dmem req/gnt to Wishbone-classic master; req->gnt 3 cycles at zero-wait (+1 per wait), 2 if misaligned.
// Core is stalled by withholding gnt_o; the slave stalls the bridge by withholding ack until timeout.
module harv_dmem_wb_bridge
  import harv_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic                  wren_i,
  input  logic [1:0]            ben_i,
  input  logic                  usgn_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST_INT = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             dat_q, dat_d;
  mem_size_t               size_q, size_d;
  logic                    usgn_q, usgn_d;
  logic [1:0]              ofs_q, ofs_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    gnt_q, gnt_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;

  mem_size_t               req_size;
  logic [1:0]              req_ofs;
  logic [31:0]             load_ext;

  assign req_size = decode_ben(ben_i);
  assign req_ofs  = addr_i[1:0];

  // Uses the latched size/offset so the core may change its pins once gnt is seen.
  harv_load_align u_load_align (
    .dat_i  (wb_dat_i),
    .size_i (size_q),
    .ofs_i  (ofs_q),
    .usgn_i (usgn_q),
    .dat_o  (load_ext)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    size_d  = size_q;
    usgn_d  = usgn_q;
    ofs_d   = ofs_q;
    cnt_d   = cnt_q;
    gnt_d   = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (misaligned(req_size, req_ofs)) begin
            state_d = RESP;
            gnt_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = wren_i;
            adr_d   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            sel_d   = lane_sel(req_size, req_ofs);
            dat_d   = lane_dat(req_size, wdata_i);
            size_d  = req_size;
            usgn_d  = usgn_i;
            ofs_d   = req_ofs;
            cnt_d   = '0;
            err_d   = 1'b0;
            rdata_d = '0;
          end
        end
      end
      BUS: begin
        if (wb_err_i || wb_ack_i || (TO_EN && cnt_q == CNT_LAST)) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          gnt_d   = 1'b1;
          // A clean ack is the only outcome that returns data, and only for loads.
          err_d   = wb_err_i || !wb_ack_i;
          rdata_d = (wb_ack_i && !wb_err_i && !we_q) ? load_ext : 32'd0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      size_q  <= SZ_BYTE;
      usgn_q  <= 1'b0;
      ofs_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      size_q  <= size_d;
      usgn_q  <= usgn_d;
      ofs_q   <= ofs_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_harv_dmem_wb_bridge.sv
// Directed bench for harv_dmem_wb_bridge with a cycle-stepped Wishbone slave.
module tb_harv_dmem_wb_bridge;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_i, wren_i, usgn_i;
  logic [1:0]  ben_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, err_o;
  logic [31:0] rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  int checks   = 0;
  int failures = 0;

  int          r_cycles, r_cyc_cnt;
  logic        r_err, r_we, r_gnt2, r_stb_ok;
  logic [31:0] r_rdata, r_adr, r_dat;
  logic [3:0]  r_sel;

  harv_dmem_wb_bridge #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .wren_i(wren_i), .ben_i(ben_i),
    .usgn_i(usgn_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .err_o(err_o),
    .rdata_o(rdata_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave. Response comes after 'waits' BUS cycles.
  task automatic run_txn(input logic wr, input logic [1:0] ben, input logic usgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input int mode);
    bit done;
    done = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; wren_i = wr; ben_i = ben; usgn_i = usgn; addr_i = addr; wdata_i = wdata;
    r_cycles = 1; r_cyc_cnt = 0; r_err = 1'b0; r_rdata = 32'hx;
    r_adr = 32'hx; r_sel = 4'hx; r_we = 1'bx; r_dat = 32'hx; r_stb_ok = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk_i); #1;
      r_cycles++;
      if (wb_cyc_o) begin
        r_cyc_cnt++;
        r_adr = wb_adr_o; r_sel = wb_sel_o; r_we = wb_we_o; r_dat = wb_dat_o;
        if (wb_stb_o !== 1'b1) r_stb_ok = 1'b0;
      end
      if (gnt_o) begin
        done = 1'b1; r_err = err_o; r_rdata = rdata_o;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (!done && wb_cyc_o && r_cyc_cnt > waits) begin
        if (mode == 0 || mode == 2) wb_ack_i = 1'b1;
        if (mode == 1 || mode == 2) wb_err_i = 1'b1;
      end
    end
    req_i = 1'b0;
    if (!done) chk("txn_bound", 32'd0, 32'd1);
    @(posedge clk_i); #1;
    r_gnt2 = gnt_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; req_i = 1'b0; wren_i = 1'b0; ben_i = 2'b00; usgn_i = 1'b0;
    addr_i = '0; wdata_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", {31'd0, gnt_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk_i) rstn_i = 1'b1;

    // word store, two wait states
    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 2, 0);
    chk("ws_adr", r_adr, 32'h100);
    chk("ws_sel", {28'd0, r_sel}, 32'hF);
    chk("ws_we", {31'd0, r_we}, 32'd1);
    chk("ws_dat", r_dat, 32'hDEADBEEF);
    chk("ws_cycles", r_cycles, 32'd5);
    chk("ws_cyc_len", r_cyc_cnt, 32'd3);
    chk("ws_err", {31'd0, r_err}, 32'd0);
    chk("ws_stb", {31'd0, r_stb_ok}, 32'd1);
    chk("ws_gnt_pulse", {31'd0, r_gnt2}, 32'd0);

    run_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 0, 0);
    chk("bs_sel", {28'd0, r_sel}, 32'h8);
    chk("bs_dat", r_dat, 32'hABABABAB);
    chk("bs_adr", r_adr, 32'h100);
    chk("bs_cycles", r_cycles, 32'd3);

    run_txn(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 0, 0);
    chk("hs_sel", {28'd0, r_sel}, 32'hC);
    chk("hs_dat", r_dat, 32'h12341234);
    chk("hs_rdata", r_rdata, 32'd0);

    wb_dat_i = 32'h0080FF00;
    run_txn(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 0, 0);
    chk("lb_s_rdata", r_rdata, 32'hFFFFFF80);
    chk("lb_s_cycles", r_cycles, 32'd3);
    chk("lb_s_sel_we", {27'd0, r_sel, r_we}, {27'd0, 4'b0100, 1'b0});
    run_txn(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 0, 0);
    chk("lb_u_rdata", r_rdata, 32'h00000080);

    wb_dat_i = 32'h80017FFF;
    run_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 0);
    chk("lh_s_rdata", r_rdata, 32'hFFFF8001);
    chk("lh_s_cycles", r_cycles, 32'd4);
    run_txn(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 0);
    chk("lh_u_rdata", r_rdata, 32'h00007FFF);
    run_txn(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 0, 0);
    chk("lw_rdata", r_rdata, 32'h80017FFF);
    chk("lw_adr", r_adr, 32'h104);
    run_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0);
    chk("lb3_rdata", r_rdata, 32'hFFFFFF80);
    chk("lb3_err", {31'd0, r_err}, 32'd0);

    // misaligned accesses never start a bus cycle
    run_txn(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, 0);
    chk("mis_h_cycles", r_cycles, 32'd2);
    chk("mis_h_err", {31'd0, r_err}, 32'd1);
    chk("mis_h_rdata", r_rdata, 32'd0);
    chk("mis_h_nocyc", r_cyc_cnt, 32'd0);
    run_txn(1'b1, 2'b10, 1'b0, 32'h102, 32'h11111111, 0, 0);
    chk("mis_w_err", {31'd0, r_err}, 32'd1);
    chk("mis_w_nocyc", r_cyc_cnt, 32'd0);

    run_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1000, 3);
    chk("to_cyc_len", r_cyc_cnt, 32'd16);
    chk("to_err", {31'd0, r_err}, 32'd1);
    chk("to_cycles", r_cycles, 32'd18);
    chk("to_rdata", r_rdata, 32'd0);
    chk("to_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);

    run_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1, 1);
    chk("be_err", {31'd0, r_err}, 32'd1);
    chk("be_rdata", r_rdata, 32'd0);
    chk("be_cycles", r_cycles, 32'd4);
    run_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, 2);
    chk("ae_err", {31'd0, r_err}, 32'd1);
    chk("ae_rdata", r_rdata, 32'd0);

    // stray ack while idle must not produce a grant
    @(negedge clk_i) wb_ack_i = 1'b1;
    @(posedge clk_i); #1;
    chk("late_ack_gnt", {30'd0, gnt_o, wb_cyc_o}, 32'd0);
    @(posedge clk_i); #1;
    chk("late_ack_gnt2", {30'd0, gnt_o, wb_cyc_o}, 32'd0);
    wb_ack_i = 1'b0;

    // reset in the second BUS cycle
    @(negedge clk_i);
    req_i = 1'b1; wren_i = 1'b0; ben_i = 2'b10; addr_i = 32'h200;
    @(posedge clk_i); #1;
    chk("rst_mid_bus1", {31'd0, wb_cyc_o}, 32'd1);
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_drop", {29'd0, wb_cyc_o, wb_stb_o, gnt_o}, 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_mid_nognt", {31'd0, gnt_o}, 32'd0);
    wb_dat_i = 32'hCAFEF00D;
    run_txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0);
    chk("post_rst_rdata", r_rdata, 32'hCAFEF00D);
    chk("post_rst_err", {31'd0, r_err}, 32'd0);
    chk("post_rst_cycles", r_cycles, 32'd3);
    chk("post_rst_adr", r_adr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
